// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, LED code
// shown while the CPU runs, and the default debounce length.
package prog_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

  localparam logic [7:0] LED_RUN_CODE = 8'hFF;

  // 10 ms of stable level at 12 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 120000;

endpackage

// File: rtl/prog_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-sample
// debouncer, and a single-cycle pulse on each accepted press.
module btn_debounce
  import prog_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK_12MHz,
  input  logic RST,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync_0;
  logic sync_1;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge CLK_12MHz or posedge RST) begin
    if (RST) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
    end else begin
      sync_0 <= btn;
      sync_1 <= sync_0;
    end
  end

  // Count consecutive samples that differ from the accepted level; any
  // sample matching the level restarts the count, so glitches are dropped.
  always_ff @(posedge CLK_12MHz or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_1;
        press <= sync_1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Front-panel program loader: debounced buttons write DIP-switch bytes
// into program memory and start/stop the CPU.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | loading mode, CPU held, waiting for a load or run press
// ST_WRITE | mem_we high for one cycle, pointer advances
// ST_RUN   | CPU released, loads ignored, run press returns to loading
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int MEM_DEPTH       = 256
) (
  input  logic       CLK_12MHz,
  input  logic       RST,
  input  logic [7:0] data_in,
  input  logic       load_btn,
  input  logic       run_btn,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       cpu_start,
  output logic       full,
  output logic [7:0] LED
);

  localparam logic [7:0] PTR_LAST = 8'(MEM_DEPTH - 1);

  state_t     state;
  logic [7:0] ptr;
  logic       run_pend;
  logic       load_level;
  logic       load_press;
  logic       run_level;
  logic       run_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .CLK_12MHz (CLK_12MHz),
    .RST       (RST),
    .btn       (load_btn),
    .level     (load_level),
    .press     (load_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .CLK_12MHz (CLK_12MHz),
    .RST       (RST),
    .btn       (run_btn),
    .level     (run_level),
    .press     (run_press)
  );

  // Loader sequencing; run presses take priority over loads, and a run
  // press seen mid-write is parked until the write has finished.
  always_ff @(posedge CLK_12MHz or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      ptr       <= 8'd0;
      full      <= 1'b0;
      run_pend  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 8'd0;
      cpu_hold  <= 1'b1;
      cpu_start <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run_press || run_pend) begin
            state     <= ST_RUN;
            run_pend  <= 1'b0;
            cpu_hold  <= 1'b0;
            cpu_start <= 1'b1;
          end else if (load_press && !full) begin
            mem_addr  <= ptr;
            mem_wdata <= data_in;
            mem_we    <= 1'b1;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (ptr == PTR_LAST) begin
            ptr  <= 8'd0;
            full <= 1'b1;
          end else begin
            ptr <= ptr + 8'd1;
          end
          if (run_press) begin
            run_pend <= 1'b1;
          end
          state <= ST_IDLE;
        end
        ST_RUN: begin
          if (run_press) begin
            state    <= ST_IDLE;
            cpu_hold <= 1'b1;
            ptr      <= 8'd0;
            full     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Front-panel LEDs: next write address, or the run code while running.
  always_comb begin
    LED = ptr;
    if (state == ST_RUN) begin
      LED = LED_RUN_CODE;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a short debounce length.
module tb_prog_loader;

  logic       CLK_12MHz;
  logic       RST;
  logic [7:0] data_in;
  logic       load_btn;
  logic       run_btn;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       cpu_start;
  logic       full;
  logic [7:0] LED;

  int n_chk = 0;
  int n_err = 0;

  int we_cnt    = 0;
  int start_cnt = 0;
  logic [7:0] last_addr = 8'd0;
  logic [7:0] last_data = 8'd0;
  logic [7:0] first_addr;
  int we_base;
  int start_base;
  int wait_n;

  prog_loader #(.DEBOUNCE_CYCLES(4), .MEM_DEPTH(256)) u_dut (
    .CLK_12MHz (CLK_12MHz),
    .RST       (RST),
    .data_in   (data_in),
    .load_btn  (load_btn),
    .run_btn   (run_btn),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .cpu_start (cpu_start),
    .full      (full),
    .LED       (LED)
  );

  initial CLK_12MHz = 1'b0;
  always #41 CLK_12MHz = ~CLK_12MHz;

  // Write-port and start-pulse monitor, sampled away from the active edge.
  always @(negedge CLK_12MHz) begin
    if (mem_we) begin
      we_cnt    = we_cnt + 1;
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
    if (cpu_start) start_cnt = start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic do_load, input logic do_run, input int hold);
    @(negedge CLK_12MHz);
    load_btn = do_load;
    run_btn  = do_run;
    repeat (hold) @(negedge CLK_12MHz);
    load_btn = 1'b0;
    run_btn  = 1'b0;
    repeat (12) @(negedge CLK_12MHz);
  endtask

  task automatic load_byte(input logic [7:0] b);
    data_in = b;
    press(1'b1, 1'b0, 6);
  endtask

  initial begin
    #(20000 * 83);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b1;
    data_in  = 8'd0;
    load_btn = 1'b0;
    run_btn  = 1'b0;
    repeat (3) @(negedge CLK_12MHz);

    // reset values
    chk("rst_we",    mem_we,    1'b0);
    chk("rst_hold",  cpu_hold,  1'b1);
    chk("rst_start", cpu_start, 1'b0);
    chk("rst_full",  full,      1'b0);
    chk("rst_led",   LED,       8'h00);
    chk("rst_addr",  mem_addr,  8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    RST = 1'b0;
    repeat (2) @(negedge CLK_12MHz);

    // three clean loads
    we_base = we_cnt;
    load_byte(8'hBF);
    chk("ld0_addr", last_addr, 8'd0);
    chk("ld0_data", last_data, 8'hBF);
    load_byte(8'hFE);
    chk("ld1_addr", last_addr, 8'd1);
    chk("ld1_data", last_data, 8'hFE);
    load_byte(8'h2B);
    chk("ld2_addr", last_addr, 8'd2);
    chk("ld2_data", last_data, 8'h2B);
    chk("ld3_count", we_cnt - we_base, 3);
    chk("ld3_led", LED, 8'd3);

    // glitch rejected, longer hold accepted once
    we_base = we_cnt;
    data_in = 8'h11;
    press(1'b1, 1'b0, 3);
    chk("glitch_no_we", we_cnt - we_base, 0);
    press(1'b1, 1'b0, 6);
    chk("hold_one_we", we_cnt - we_base, 1);
    chk("hold_addr", last_addr, 8'd3);
    chk("hold_led", LED, 8'd4);

    // load and run in the same cycle: run wins
    we_base    = we_cnt;
    start_base = start_cnt;
    data_in    = 8'h99;
    press(1'b1, 1'b1, 6);
    chk("both_no_we", we_cnt - we_base, 0);
    chk("both_start_1cyc", start_cnt - start_base, 1);
    chk("both_hold", cpu_hold, 1'b0);
    chk("both_led", LED, 8'hFF);

    // loads ignored while running
    press(1'b1, 1'b0, 6);
    chk("run_load_ignored", we_cnt - we_base, 0);

    // back to loading: pointer cleared
    press(1'b0, 1'b1, 6);
    chk("stop_hold", cpu_hold, 1'b1);
    chk("stop_led", LED, 8'h00);
    chk("stop_full", full, 1'b0);
    load_byte(8'h5A);
    chk("stop_next_addr", last_addr, 8'd0);
    chk("stop_next_data", last_data, 8'h5A);

    // run press landing on the write cycle is deferred until after the write
    we_base    = we_cnt;
    start_base = start_cnt;
    data_in    = 8'h77;
    @(negedge CLK_12MHz);
    load_btn = 1'b1;
    @(negedge CLK_12MHz);
    run_btn = 1'b1;
    repeat (7) @(negedge CLK_12MHz);
    load_btn = 1'b0;
    @(negedge CLK_12MHz);
    run_btn = 1'b0;
    repeat (12) @(negedge CLK_12MHz);
    chk("defer_we", we_cnt - we_base, 1);
    chk("defer_addr", last_addr, 8'd1);
    chk("defer_data", last_data, 8'h77);
    chk("defer_start", start_cnt - start_base, 1);
    chk("defer_hold", cpu_hold, 1'b0);
    press(1'b0, 1'b1, 6);
    chk("defer_stop_led", LED, 8'h00);

    // fill all 256 locations
    we_base = we_cnt;
    for (int i = 0; i < 256; i++) begin
      load_byte(8'(i));
      if (i == 0) first_addr = last_addr;
      if (i == 254) chk("full_before_last", full, 1'b0);
    end
    chk("fill_count", we_cnt - we_base, 256);
    chk("fill_first_addr", first_addr, 8'd0);
    chk("fill_last_addr", last_addr, 8'd255);
    chk("fill_last_data", last_data, 8'd255);
    chk("fill_mem_addr", mem_addr, 8'd255);
    chk("fill_full", full, 1'b1);
    chk("fill_led_wrap", LED, 8'd0);
    we_base = we_cnt;
    load_byte(8'hAA);
    chk("full_ignored", we_cnt - we_base, 0);
    chk("full_mem_addr", mem_addr, 8'd255);

    // reset asserted during the write cycle
    @(negedge CLK_12MHz);
    RST = 1'b1;
    repeat (2) @(negedge CLK_12MHz);
    RST = 1'b0;
    repeat (2) @(negedge CLK_12MHz);
    data_in  = 8'hC3;
    load_btn = 1'b1;
    wait_n   = 0;
    while (!mem_we && wait_n < 50) begin
      @(negedge CLK_12MHz);
      wait_n++;
    end
    chk("abort_we_seen", mem_we, 1'b1);
    #5;
    RST = 1'b1;
    #1;
    chk("abort_we_async", mem_we, 1'b0);
    chk("abort_hold", cpu_hold, 1'b1);
    chk("abort_full", full, 1'b0);
    chk("abort_led", LED, 8'h00);
    chk("abort_addr", mem_addr, 8'h00);
    chk("abort_wdata", mem_wdata, 8'h00);
    load_btn = 1'b0;
    repeat (3) @(negedge CLK_12MHz);
    RST = 1'b0;
    we_base = we_cnt;
    repeat (20) @(negedge CLK_12MHz);
    chk("abort_no_write", we_cnt - we_base, 0);
    chk("abort_hold_after", cpu_hold, 1'b1);

    // button already held across reset release gives one press
    RST      = 1'b1;
    data_in  = 8'h3C;
    load_btn = 1'b1;
    repeat (2) @(negedge CLK_12MHz);
    we_base = we_cnt;
    RST     = 1'b0;
    repeat (20) @(negedge CLK_12MHz);
    load_btn = 1'b0;
    repeat (12) @(negedge CLK_12MHz);
    chk("held_one_we", we_cnt - we_base, 1);
    chk("held_addr", last_addr, 8'd0);
    chk("held_data", last_data, 8'h3C);
    chk("held_led", LED, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, stable-input cycles needed to accept a button level (10 ms at 12 MHz).
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of writable program-memory bytes.
REQ-003 CLK_12MHz  input  1  sole clock; all state on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  8  byte to load (from DPSwitch).
REQ-006 load_btn  input  1  raw asynchronous button; a debounced press writes data_in.
REQ-007 run_btn  input  1  raw asynchronous button; a debounced press toggles run/load.
REQ-008 mem_we  output  1  one-cycle write strobe to program memory.
REQ-009 mem_addr  output  8  write address.
REQ-010 mem_wdata  output  8  write data.
REQ-011 cpu_hold  output  1  high holds the CPU in START with pc=0.
REQ-012 cpu_start  output  1  one-cycle pulse when the CPU is released.
REQ-013 full  output  1  all MEM_DEPTH bytes have been written since the last clear.
REQ-014 LED  output  8  next write address while loading; 8'hFF while running.

Function
REQ-015 Each button SHALL pass a 2-flop synchronizer, then a debouncer that takes the new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-016 Each debouncer SHALL emit exactly one 1-cycle press pulse per debounced 0->1 transition; release SHALL give no pulse.
REQ-017 The FSM SHALL have states IDLE, WRITE and RUN.
REQ-018 IDLE + load pulse + full=0: data_in and the address pointer SHALL be captured; go to WRITE.
REQ-019 WRITE: mem_we=1 for exactly one cycle with the captured address and data; the pointer increments; return to IDLE.
REQ-020 mem_we SHALL rise on the cycle after the load pulse (latency 1).
REQ-021 The pointer SHALL be 8 bits; a write at MEM_DEPTH-1 wraps it to 0 and sets full=1.
REQ-022 While full=1, load pulses SHALL be ignored: no mem_we, pointer unchanged.
REQ-023 IDLE + run pulse: go to RUN next cycle; cpu_hold falls and cpu_start pulses high for that one cycle.
REQ-024 Load and run pulses in the same IDLE cycle: run SHALL win and the load is discarded.
REQ-025 A run pulse in WRITE SHALL be registered and take effect in the following IDLE cycle, after the write completes.
REQ-026 In RUN, load pulses SHALL be ignored and mem_we held 0.
REQ-027 RUN + run pulse: go to IDLE; cpu_hold=1 next cycle; pointer and full cleared to 0.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-029 RST=1 SHALL immediately force state=IDLE, mem_we=0, cpu_hold=1, cpu_start=0, full=0, pointer=0, mem_addr=0, mem_wdata=0, LED=0, with debouncers cleared to level 0 and counter 0.
REQ-030 Reset asserted during WRITE SHALL abort the write (mem_we low asynchronously); no partial write follows deassertion.
REQ-031 After deassertion, a button already held SHALL produce one press pulse once stable for DEBOUNCE_CYCLES.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/WRITE/RUN), LED_RUN_CODE=8'hFF and the default DEBOUNCE_CYCLES.
REQ-033 Debounce SHALL be one sub-module, btn_debounce (sync, counter, edge pulse), instantiated for load_btn and run_btn.
REQ-034 Memory SHALL stay outside this block; prog_loader only drives the write port.

Verification (DEBOUNCE_CYCLES=4 on the bench)
REQ-035 Load 8'hBF, 8'hFE, 8'h2B with clean presses -> three mem_we pulses at addr 0,1,2 with that data; LED=3.
REQ-036 A 3-cycle glitch on load_btn -> no mem_we; a 6-cycle hold -> exactly one mem_we.
REQ-037 256 loads -> full=1 after the write at addr 255, mem_addr=255; a 257th load -> no mem_we.
REQ-038 Load and run pulses in the same cycle -> cpu_start one cycle, cpu_hold=0, no mem_we, LED=8'hFF.
REQ-039 RUN then run press -> cpu_hold=1, LED=0, full=0; the next load writes addr 0.
REQ-040 RST asserted on the WRITE cycle -> mem_we drops without waiting for a clock; after release all outputs are at reset values and no write occurs.
